// File: rtl/wallace_multiplier.sv
// Unsigned 4x4 Wallace-tree multiplier with a registered 8-bit product.
// Partial-product bits are reduced by half/full adders in two stages
// (column heights 4 -> 3 -> 2). A ripple adder over columns 1..6 then
// resolves the last two rows. Its carry-out is the product MSB.

// Half adder: two bits of equal weight in, sum and carry out.
module ha (
  input  logic x,
  input  logic y,
  output logic sum,
  output logic carry
);
  assign sum   = x ^ y;
  assign carry = x & y;
endmodule

// Full adder: three bits of equal weight in, sum and majority carry out.
module fa (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic sum,
  output logic carry
);
  assign sum   = x ^ y ^ z;
  assign carry = (x & y) | (x & z) | (y & z);
endmodule

module wallace_multiplier (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] prod
);

  // Partial products. PPn is a gated by b[n-1] and has weight 2^(n-1).
  // These names are kept stable so a bench can probe them hierarchically.
  logic [3:0] PP1;
  logic [3:0] PP2;
  logic [3:0] PP3;
  logic [3:0] PP4;

  assign PP1 = a & {4{b[0]}};
  assign PP2 = a & {4{b[1]}};
  assign PP3 = a & {4{b[2]}};
  assign PP4 = a & {4{b[3]}};

  // Initial column contents (weight : bits)
  //   0 : PP1[0]
  //   1 : PP1[1] PP2[0]
  //   2 : PP1[2] PP2[1] PP3[0]
  //   3 : PP1[3] PP2[2] PP3[1] PP4[0]
  //   4 : PP2[3] PP3[2] PP4[1]
  //   5 : PP3[3] PP4[2]
  //   6 : PP4[3]

  // Stage 1 brings every column down to height 3 or less.
  // Only the columns that would overflow after incoming carries are touched.
  logic s1_c2_sum, s1_c2_carry;
  logic s1_c3_sum, s1_c3_carry;
  logic s1_c4_sum, s1_c4_carry;

  ha u_s1_c2 (.x(PP1[2]), .y(PP2[1]),                .sum(s1_c2_sum), .carry(s1_c2_carry));
  fa u_s1_c3 (.x(PP1[3]), .y(PP2[2]), .z(PP3[1]),    .sum(s1_c3_sum), .carry(s1_c3_carry));
  ha u_s1_c4 (.x(PP2[3]), .y(PP3[2]),                .sum(s1_c4_sum), .carry(s1_c4_carry));

  // Column contents after stage 1
  //   0 : PP1[0]
  //   1 : PP1[1] PP2[0]
  //   2 : s1_c2_sum PP3[0]
  //   3 : s1_c3_sum PP4[0] s1_c2_carry
  //   4 : s1_c4_sum PP4[1] s1_c3_carry
  //   5 : PP3[3] PP4[2] s1_c4_carry
  //   6 : PP4[3]

  // Stage 2 reduces the height-3 columns 3..5 to height 2.
  logic s2_c3_sum, s2_c3_carry;
  logic s2_c4_sum, s2_c4_carry;
  logic s2_c5_sum, s2_c5_carry;

  fa u_s2_c3 (.x(s1_c3_sum), .y(PP4[0]), .z(s1_c2_carry), .sum(s2_c3_sum), .carry(s2_c3_carry));
  fa u_s2_c4 (.x(s1_c4_sum), .y(PP4[1]), .z(s1_c3_carry), .sum(s2_c4_sum), .carry(s2_c4_carry));
  fa u_s2_c5 (.x(PP3[3]),    .y(PP4[2]), .z(s1_c4_carry), .sum(s2_c5_sum), .carry(s2_c5_carry));

  // Column contents after stage 2 (two rows at most)
  //   0 : PP1[0]
  //   1 : PP1[1] PP2[0]
  //   2 : s1_c2_sum PP3[0]
  //   3 : s2_c3_sum
  //   4 : s2_c4_sum s2_c3_carry
  //   5 : s2_c5_sum s2_c4_carry
  //   6 : PP4[3]    s2_c5_carry

  // Final carry-propagate adder. It ripples across columns 1..6.
  // Column 3 has a single row, so a half adder is enough there.
  logic [6:1] cpa_sum;
  logic [6:1] cpa_carry;

  ha u_cpa_c1 (.x(PP1[1]),    .y(PP2[0]),                          .sum(cpa_sum[1]), .carry(cpa_carry[1]));
  fa u_cpa_c2 (.x(s1_c2_sum), .y(PP3[0]),      .z(cpa_carry[1]),   .sum(cpa_sum[2]), .carry(cpa_carry[2]));
  ha u_cpa_c3 (.x(s2_c3_sum), .y(cpa_carry[2]),                    .sum(cpa_sum[3]), .carry(cpa_carry[3]));
  fa u_cpa_c4 (.x(s2_c4_sum), .y(s2_c3_carry), .z(cpa_carry[3]),   .sum(cpa_sum[4]), .carry(cpa_carry[4]));
  fa u_cpa_c5 (.x(s2_c5_sum), .y(s2_c4_carry), .z(cpa_carry[4]),   .sum(cpa_sum[5]), .carry(cpa_carry[5]));
  fa u_cpa_c6 (.x(PP4[3]),    .y(s2_c5_carry), .z(cpa_carry[5]),   .sum(cpa_sum[6]), .carry(cpa_carry[6]));

  logic [7:0] prod_comb;
  assign prod_comb = {cpa_carry[6], cpa_sum[6:1], PP1[0]};

  // Output register: reset has priority; otherwise capture this cycle's product.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod <= 8'h00;
    end else begin
      prod <= prod_comb;
    end
  end

endmodule

// File: tb/tb_wallace_multiplier.sv
// Directed and randomized bench for wallace_multiplier.
// Each expected value is computed with plain integer multiplication.
module tb_wallace_multiplier;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic [7:0] prod;

  int passed;
  int total;
  int failed;

  wallace_multiplier dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .prod (prod)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_mul(input int x, input int y);
    int p;
    p = x * y;
    return p[7:0];
  endfunction

  // Drive the operands and reset, take one rising edge, then sample 1 time unit later.
  task automatic step(input logic [3:0] ai, input logic [3:0] bi, input logic r,
                      input string tag);
    a   = ai;
    b   = bi;
    rst = r;
    @(posedge clk);
    #1;
    check8(tag, prod, r ? 8'h00 : ref_mul(int'(ai), int'(bi)));
  endtask

  initial begin
    logic [3:0] ra;
    logic [3:0] rb;
    logic [7:0] held;

    passed = 0;
    total  = 0;
    failed = 0;
    rst = 1'b1;
    a   = 4'h0;
    b   = 4'h0;
    @(negedge clk);

    // Reset with both operands at maximum, then release it and hold the operands.
    step(4'hF, 4'hF, 1'b1, "reset_ff");
    step(4'hF, 4'hF, 1'b0, "release_ff");
    check8("release_ff_const", prod, 8'hE1);

    // Zero operands.
    step(4'd0, 4'd9, 1'b0, "zero_a");
    step(4'd7, 4'd0, 1'b0, "zero_b");
    check4("pp1_b0", dut.PP1, 4'b0000);
    check4("pp2_b0", dut.PP2, 4'b0000);
    check4("pp3_b0", dut.PP3, 4'b0000);
    check4("pp4_b0", dut.PP4, 4'b0000);

    // Partial products follow the operands combinationally; the product is registered.
    a = 4'b1011;
    b = 4'b0101;
    #1;
    check4("pp1_b5", dut.PP1, 4'b1011);
    check4("pp2_b5", dut.PP2, 4'b0000);
    check4("pp3_b5", dut.PP3, 4'b1011);
    check4("pp4_b5", dut.PP4, 4'b0000);
    check8("no_comb_path", prod, 8'h00);
    step(4'b1011, 4'b0101, 1'b0, "pp_prod");
    check8("pp_prod_const", prod, 8'h37);

    // Operands that change between clock edges must not disturb the held product.
    held = prod;
    #2;
    a = 4'd3;
    b = 4'd3;
    #2;
    check8("hold_between_edges", prod, held);

    // Triangular sweep.
    for (int i = 1; i <= 15; i++) begin
      for (int j = 1; j <= i; j++) begin
        step(4'(i), 4'(j), 1'b0, "tri_sweep");
      end
    end
    step(4'd13, 4'd11, 1'b0, "tri_13x11");
    check8("tri_13x11_const", prod, 8'h8F);

    // Exhaustive back-to-back sweep. The operands change on every cycle.
    for (int k = 0; k < 256; k++) begin
      step(4'(k >> 4), 4'(k & 15), 1'b0, "exhaustive");
    end

    // Reset mid-stream.
    step(4'd12, 4'd10, 1'b0, "mid_pre");
    step(4'd12, 4'd10, 1'b1, "mid_reset");
    step(4'd12, 4'd10, 1'b0, "mid_release");
    check8("mid_release_const", prod, 8'h78);

    // Randomized operands, with an occasional reset pulse.
    for (int n = 0; n < 300; n++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      step(ra, rb, ($urandom_range(0, 19) == 0), "random");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/wallace_multiplier.md
# wallace_multiplier

Unsigned 4x4-bit Wallace-tree multiplier producing an 8-bit product, with a registered output stage. Used as a standalone arithmetic datapath block: operands are presented every cycle and the product appears one clock later. The reduction is built strictly from half/full adders in a Wallace tree, followed by a final carry-propagate adder.

## Interface
- Parameters: none; operand widths fixed at 4 bits, product at 8 bits.
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  reset, synchronous and active-high.
- a  input  4  unsigned multiplicand.
- b  input  4  unsigned multiplier.
- prod  output  8  registered unsigned product a*b.

## Operation
- Partial products as named internal 4-bit signals, visible hierarchically to benches: PP1 = a & {4{b[0]}} (weight 2^0), PP2 = a & {4{b[1]}} (weight 2^1), PP3 = a & {4{b[2]}} (weight 2^2), PP4 = a & {4{b[3]}} (weight 2^3).
- Reduction: 16 partial-product bits arranged by column weight 0..6; columns reduced with full adders (3:2) and half adders (2:2) in Wallace-tree stages until every column holds at most two bits; carries go to column+1.
- Stage count: two reduction stages (heights 4 -> 3 -> 2), then one final carry-propagate (ripple) adder over columns 1..6; column 0 passes PP1[0] straight through.
- Final adder carry-out forms prod[7]; no truncation, no overflow possible (15*15 = 225 < 256).
- Half/full adders implemented as separate reusable submodules (ha: sum=x^y, carry=x&y; fa: sum=x^y^z, carry=majority).
- Combinational result registered into prod on each rising clk edge.
- Arithmetic strictly unsigned; no sign extension.

## Timing
- Latency: 1 cycle. Operands stable before rising edge N -> prod = a*b after edge N.
- Throughput: one product per cycle; new operands accepted every cycle, no handshake, no stall.
- Reset: when rst=1 at a rising edge, prod <= 8'h00 regardless of a/b; rst has priority over the load.
- Reset mid-stream: product of the operands present at the reset edge is discarded; first edge with rst=0 loads the current a*b.
- After power-up and before first reset edge prod is undefined; benches must reset first.
- Operand changes between edges do not affect prod until the next edge; no combinational path from a/b to prod.
- Partial products PP1..PP4 are combinational and follow a/b immediately.

## Test plan
- Reset: rst=1 one edge with a=4'hF, b=4'hF -> prod=8'h00; release rst, hold operands -> next edge prod=8'hE1 (225).
- Zero operand: a=0, b=9 -> prod=0; a=7, b=0 -> prod=0; PP1..PP4 all 4'b0000 for b=0.
- Triangular sweep: for i=1..15, j=1..i, apply a=i, b=j -> prod=i*j one cycle later (e.g. 13*11=143=8'h8F, 15*1=15).
- Full exhaustive 256-pair sweep with back-to-back changes each cycle -> each prod equals product of operands from previous edge (pipelining check, no stale or skipped results).
- Partial products: a=4'b1011, b=4'b0101 -> PP1=1011, PP2=0000, PP3=1011, PP4=0000, prod=55 (8'h37).
- Reset mid-operation: a=12, b=10 stable, assert rst for one edge -> prod=0; deassert -> next edge prod=120 (8'h78).
